// File: rtl/board_state.sv
// Card-grid state for a 6x6 pairs game: shuffled layout, cursor, selection/match FSM
// and a registered per-cell colour lookup for the downstream display stage.
module board_state #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic        clk100_in,
  input  logic        rst_n_in,
  input  logic        btn_up_in,
  input  logic        btn_down_in,
  input  logic        btn_left_in,
  input  logic        btn_right_in,
  input  logic        btn_sel_in,
  input  logic [5:0]  addr_in,
  output logic [2:0]  r,
  output logic [2:0]  g,
  output logic [1:0]  b,
  output logic [35:0] hidden_bus,
  output logic [35:0] blink_bus,
  output logic [35:0] sel_bus,
  output logic [4:0]  pairs_left,
  output logic        cleared
);

  localparam int unsigned NCELL = 36;

  typedef enum logic [2:0] {
    S_INIT,
    S_SHUFFLE,
    S_IDLE,
    S_ONE,
    S_CHECK,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  card_q [NCELL];
  logic [7:0]  lfsr_q, lfsr_d;
  logic [5:0]  k_q, k_d;
  logic [2:0]  row_q, row_d, col_q, col_d;
  logic [5:0]  first_q, first_d, second_q, second_d;
  logic [35:0] hidden_q, hidden_d, sel_q, sel_d, blink_q, blink_d;
  logic [4:0]  pairs_q, pairs_d;
  logic        cleared_q, cleared_d;
  logic [7:0]  rgb_q, rgb_d;

  logic [5:0]  cur, cur_nxt, shuf_j;
  logic [7:0]  lfsr_next;

  function automatic logic [2:0] dec6(input logic [2:0] v);
    return (v == 3'd0) ? 3'd5 : v - 3'd1;
  endfunction

  function automatic logic [2:0] inc6(input logic [2:0] v);
    return (v == 3'd5) ? 3'd0 : v + 3'd1;
  endfunction

  assign cur       = {3'b000, row_q} * 6'd6 + {3'b000, col_q};
  assign cur_nxt   = {3'b000, row_d} * 6'd6 + {3'b000, col_d};
  assign shuf_j    = (lfsr_q[5:0] >= 6'd36) ? lfsr_q[5:0] - 6'd36 : lfsr_q[5:0];
  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    k_d       = k_q;
    row_d     = row_q;
    col_d     = col_q;
    first_d   = first_q;
    second_d  = second_q;
    hidden_d  = hidden_q;
    sel_d     = sel_q;
    pairs_d   = pairs_q;
    cleared_d = cleared_q;

    case (state_q)
      S_INIT: begin
        lfsr_d  = SEED;
        k_d     = 6'd0;
        state_d = S_SHUFFLE;
      end
      S_SHUFFLE: begin
        lfsr_d = lfsr_next;
        k_d    = k_q + 6'd1;
        if (k_q == 6'd35) state_d = S_IDLE;
      end
      S_IDLE, S_ONE: begin
        if (btn_sel_in) begin
          if (state_q == S_IDLE) begin
            if (!hidden_q[cur]) begin
              first_d    = cur;
              sel_d[cur] = 1'b1;
              state_d    = S_ONE;
            end
          end else if (cur == first_q) begin
            sel_d[first_q] = 1'b0;
            state_d        = S_IDLE;
          end else if (!hidden_q[cur]) begin
            sel_d[cur] = 1'b1;
            second_d   = cur;
            state_d    = S_CHECK;
          end
        end else if (btn_up_in) begin
          row_d = dec6(row_q);
        end else if (btn_down_in) begin
          row_d = inc6(row_q);
        end else if (btn_left_in) begin
          col_d = dec6(col_q);
        end else if (btn_right_in) begin
          col_d = inc6(col_q);
        end
      end
      S_CHECK: begin
        sel_d   = '0;
        state_d = S_IDLE;
        if (card_q[first_q] == card_q[second_q]) begin
          hidden_d[first_q]  = 1'b1;
          hidden_d[second_q] = 1'b1;
          pairs_d            = pairs_q - 5'd1;
          if (pairs_q == 5'd1) begin
            state_d   = S_DONE;
            cleared_d = 1'b1;
          end
        end
      end
      S_DONE: ;
      default: state_d = S_INIT;
    endcase

    // Cursor highlight tracks the cursor only while the player can move it.
    blink_d = (state_d == S_IDLE || state_d == S_ONE) ? (36'd1 << cur_nxt) : '0;
    rgb_d   = (addr_in < 6'd36) ? 8'd12 + {3'b000, card_q[addr_in]} * 8'd13 : 8'd0;
  end

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk100_in) begin
    if (!rst_n_in) begin
      state_q   <= S_INIT;
      lfsr_q    <= SEED;
      k_q       <= 6'd0;
      row_q     <= 3'd0;
      col_q     <= 3'd0;
      first_q   <= 6'd0;
      second_q  <= 6'd0;
      hidden_q  <= '0;
      sel_q     <= '0;
      blink_q   <= '0;
      pairs_q   <= 5'd18;
      cleared_q <= 1'b0;
      rgb_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      k_q       <= k_d;
      row_q     <= row_d;
      col_q     <= col_d;
      first_q   <= first_d;
      second_q  <= second_d;
      hidden_q  <= hidden_d;
      sel_q     <= sel_d;
      blink_q   <= blink_d;
      pairs_q   <= pairs_d;
      cleared_q <= cleared_d;
      rgb_q     <= rgb_d;
    end
  end

  // NOTE: the card array has no reset; INIT rewrites every entry before it is ever used.
  always_ff @(posedge clk100_in) begin
    if (state_q == S_INIT) begin
      for (int i = 0; i < NCELL; i++) card_q[i] <= 5'(i >> 1);
    end else if (state_q == S_SHUFFLE) begin
      card_q[k_q]    <= card_q[shuf_j];
      card_q[shuf_j] <= card_q[k_q];
    end
  end

  assign {r, g, b}  = rgb_q;
  assign hidden_bus = hidden_q;
  assign blink_bus  = blink_q;
  assign sel_bus    = sel_q;
  assign pairs_left = pairs_q;
  assign cleared    = cleared_q;

endmodule

// File: tb/tb_board_state.sv
// Bench for board_state: directed game scenarios plus random button traffic, all
// checked against a cell-list reference model of the board.
module tb_board_state;

  localparam logic [7:0] SEED    = 8'hA5;
  localparam logic [4:0] B_NONE  = 5'b00000;
  localparam logic [4:0] B_SEL   = 5'b10000;
  localparam logic [4:0] B_UP    = 5'b01000;
  localparam logic [4:0] B_DOWN  = 5'b00100;
  localparam logic [4:0] B_LEFT  = 5'b00010;
  localparam logic [4:0] B_RIGHT = 5'b00001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic [5:0]  addr_in;
  logic [2:0]  r, g;
  logic [1:0]  b;
  logic [35:0] hidden_bus, blink_bus, sel_bus;
  logic [4:0]  pairs_left;
  logic        cleared;
  logic [7:0]  rgb;

  int total = 0;
  int bad   = 0;

  // Reference model: card list, cursor, selected cells, flags.
  int          m_card [36];
  int          m_row, m_col, m_first, m_second, m_pairs;
  bit          m_checking, m_done;
  logic [35:0] m_hidden;

  always #5 clk = ~clk;

  board_state #(.SEED(SEED)) dut (
    .clk100_in   (clk),
    .rst_n_in    (rst_n),
    .btn_up_in   (btn_up),
    .btn_down_in (btn_down),
    .btn_left_in (btn_left),
    .btn_right_in(btn_right),
    .btn_sel_in  (btn_sel),
    .addr_in     (addr_in),
    .r           (r),
    .g           (g),
    .b           (b),
    .hidden_bus  (hidden_bus),
    .blink_bus   (blink_bus),
    .sel_bus     (sel_bus),
    .pairs_left  (pairs_left),
    .cleared     (cleared)
  );

  assign rgb = {r, g, b};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] colour(input int a);
    if (a >= 36) return 8'd0;
    return 8'(12 + 13 * m_card[a]);
  endfunction

  function automatic logic [35:0] onehot(input int c);
    logic [35:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic model_shuffle();
    logic [7:0] lf;
    int j, t;
    lf = SEED;
    for (int i = 0; i < 36; i++) m_card[i] = i / 2;
    for (int k = 0; k < 36; k++) begin
      j = int'(lf[5:0]);
      if (j >= 36) j -= 36;
      t         = m_card[k];
      m_card[k] = m_card[j];
      m_card[j] = t;
      lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
    end
  endtask

  function automatic void model_init();
    m_row = 0; m_col = 0; m_first = -1; m_second = -1;
    m_checking = 1'b0; m_done = 1'b0; m_hidden = '0; m_pairs = 18;
  endfunction

  function automatic void model_step(input logic [4:0] m);
    int cur;
    cur = m_row * 6 + m_col;
    if (m_done) return;
    if (m_checking) begin
      if (m_card[m_first] == m_card[m_second]) begin
        m_hidden[m_first]  = 1'b1;
        m_hidden[m_second] = 1'b1;
        m_pairs--;
        if (m_pairs == 0) m_done = 1'b1;
      end
      m_first    = -1;
      m_checking = 1'b0;
      return;
    end
    if (m[4]) begin
      if (m_first < 0) begin
        if (!m_hidden[cur]) m_first = cur;
      end else if (cur == m_first) begin
        m_first = -1;
      end else if (!m_hidden[cur]) begin
        m_second   = cur;
        m_checking = 1'b1;
      end
    end else if (m[3]) m_row = (m_row + 5) % 6;
    else if (m[2]) m_row = (m_row + 1) % 6;
    else if (m[1]) m_col = (m_col + 5) % 6;
    else if (m[0]) m_col = (m_col + 1) % 6;
  endfunction

  function automatic logic [35:0] exp_sel();
    logic [35:0] s;
    s = '0;
    if (m_first >= 0) s[m_first] = 1'b1;
    if (m_checking) s[m_second] = 1'b1;
    return s;
  endfunction

  function automatic logic [35:0] exp_blink();
    if (m_done || m_checking) return '0;
    return onehot(m_row * 6 + m_col);
  endfunction

  // One cycle with the given buttons and a random colour address, then full compare.
  task automatic act(input logic [4:0] m);
    int a;
    a = $urandom_range(0, 63);
    addr_in = 6'(a);
    {btn_sel, btn_up, btn_down, btn_left, btn_right} = m;
    tick();
    {btn_sel, btn_up, btn_down, btn_left, btn_right} = B_NONE;
    model_step(m);
    check("rgb",     64'(rgb),        64'(colour(a)));
    check("blink",   64'(blink_bus),  64'(exp_blink()));
    check("sel",     64'(sel_bus),    64'(exp_sel()));
    check("hidden",  64'(hidden_bus), 64'(m_hidden));
    check("pairs",   64'(pairs_left), 64'(m_pairs));
    check("cleared", 64'(cleared),    64'(m_done));
  endtask

  task automatic goto_cell(input int t);
    if (m_checking) act(B_NONE);
    if (m_done) return;
    while (m_row != t / 6) act(B_DOWN);
    while (m_col != t % 6) act(B_RIGHT);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_hidden"},  64'(hidden_bus), 64'd0);
    check({tag, "_sel"},     64'(sel_bus),    64'd0);
    check({tag, "_blink"},   64'(blink_bus),  64'd0);
    check({tag, "_rgb"},     64'(rgb),        64'd0);
    check({tag, "_pairs"},   64'(pairs_left), 64'd18);
    check({tag, "_cleared"}, 64'(cleared),    64'd0);
  endtask

  initial begin
    int cnt [18];
    int p, ca, cb, c1, c2, v, sel;
    logic [35:0] hid_save;

    rst_n = 1'b0;
    {btn_sel, btn_up, btn_down, btn_left, btn_right} = B_NONE;
    addr_in = 6'd0;
    model_shuffle();
    model_init();

    // Reset and boot timing.
    tick(); tick();
    check_reset("por");
    rst_n = 1'b1;
    repeat (36) tick();
    check("boot36_blink", 64'(blink_bus), 64'd0);
    tick();
    check("boot37_blink",  64'(blink_bus),  64'd1);
    check("boot37_pairs",  64'(pairs_left), 64'd18);
    check("boot37_hidden", 64'(hidden_bus), 64'd0);

    // Colour scan: layout matches the model and every type appears twice.
    for (int t = 0; t < 18; t++) cnt[t] = 0;
    for (int i = 0; i < 36; i++) begin
      addr_in = 6'(i);
      tick();
      check($sformatf("scan%0d", i), 64'(rgb), 64'(colour(i)));
      v = (int'(rgb) - 12) / 13;
      if (int'(rgb) >= 12 && v < 18) cnt[v]++;
    end
    for (int t = 0; t < 18; t++) check($sformatf("type%0d_count", t), 64'(cnt[t]), 64'd2);
    addr_in = 6'd40;
    tick();
    check("addr40_rgb", 64'(rgb), 64'd0);
    addr_in = 6'd35;
    tick();
    check("addr35_rgb", 64'(rgb), 64'(colour(35)));

    // Cursor wrap.
    act(B_LEFT);
    check("wrap_left", 64'(blink_bus), 64'(36'd1 << 5));
    act(B_UP);
    check("wrap_up", 64'(blink_bus), 64'(36'd1 << 35));
    act(B_RIGHT);
    act(B_DOWN);
    check("wrap_home", 64'(blink_bus), 64'd1);

    // Match cell 0 with its partner.
    p = 0;
    for (int i = 1; i < 36; i++) if (m_card[i] == m_card[0]) p = i;
    act(B_SEL);
    check("sel_first", 64'(sel_bus), 64'd1);
    goto_cell(p);
    act(B_SEL);
    check("sel_pair", 64'(sel_bus), 64'(36'd1 | (36'd1 << p)));
    act(B_NONE);
    check("match_hidden", 64'(hidden_bus), 64'(36'd1 | (36'd1 << p)));
    check("match_pairs",  64'(pairs_left), 64'd17);
    check("match_sel",    64'(sel_bus),    64'd0);

    // Mismatch, with a left pulse dropped during CHECK.
    ca = -1; cb = -1;
    for (int i = 0; i < 36; i++) if (ca < 0 && !m_hidden[i]) ca = i;
    for (int i = 0; i < 36; i++) if (cb < 0 && !m_hidden[i] && m_card[i] != m_card[ca]) cb = i;
    hid_save = m_hidden;
    goto_cell(ca);
    act(B_SEL);
    goto_cell(cb);
    act(B_SEL);
    act(B_LEFT);
    check("miss_hidden", 64'(hidden_bus), 64'(hid_save));
    check("miss_pairs",  64'(pairs_left), 64'd17);
    check("miss_sel",    64'(sel_bus),    64'd0);
    check("check_left_ignored", 64'(blink_bus), 64'(36'd1 << cb));

    // Deselect by selecting the same cell twice; a further sel reselects from IDLE.
    act(B_SEL);
    check("desel_a", 64'(sel_bus), 64'(36'd1 << cb));
    act(B_SEL);
    check("desel_b", 64'(sel_bus), 64'd0);
    act(B_SEL);
    check("desel_c", 64'(sel_bus), 64'(36'd1 << cb));
    act(B_SEL);

    // Select on a hidden cell is ignored; moving off it still works.
    goto_cell(0);
    act(B_SEL);
    check("sel_hidden", 64'(sel_bus), 64'd0);
    act(B_RIGHT);
    check("move_off_hidden", 64'(blink_bus), 64'(36'd1 << 1));

    // sel and right together: selection wins, cursor stays.
    goto_cell(ca);
    act(B_SEL | B_RIGHT);
    check("selright_sel",   64'(sel_bus),   64'(36'd1 << ca));
    check("selright_blink", 64'(blink_bus), 64'(36'd1 << ca));
    act(B_SEL);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: act(B_SEL);
        1: act(B_UP);
        2: act(B_DOWN);
        3: act(B_LEFT);
        4: act(B_RIGHT);
        5: act(5'($urandom_range(0, 31)));
        default: act(B_NONE);
      endcase
    end

    // Clear the remaining pairs.
    if (m_checking) act(B_NONE);
    if (m_first >= 0) begin
      goto_cell(m_first);
      act(B_SEL);
    end
    for (int t = 0; t < 18; t++) begin
      c1 = -1; c2 = -1;
      for (int i = 0; i < 36; i++)
        if (m_card[i] == t) begin
          if (c1 < 0) c1 = i;
          else c2 = i;
        end
      if (c1 >= 0 && c2 >= 0 && !m_hidden[c1]) begin
        goto_cell(c1);
        act(B_SEL);
        goto_cell(c2);
        act(B_SEL);
        act(B_NONE);
      end
    end
    check("done_cleared", 64'(cleared),    64'd1);
    check("done_pairs",   64'(pairs_left), 64'd0);
    check("done_hidden",  64'(hidden_bus), 64'(36'hF_FFFF_FFFF));
    check("done_blink",   64'(blink_bus),  64'd0);
    act(B_SEL);
    act(B_LEFT);

    // Reset from DONE, mid-SHUFFLE and in CHECK.
    rst_n = 1'b0;
    tick();
    check_reset("rst_done");
    rst_n = 1'b1;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    check_reset("rst_shuffle");
    rst_n = 1'b1;
    repeat (37) tick();
    model_init();
    check("reboot_blink", 64'(blink_bus), 64'd1);
    act(B_SEL);
    act(B_RIGHT);
    act(B_SEL);
    check("pre_rst_check_sel", 64'(sel_bus), 64'd3);
    rst_n = 1'b0;
    tick();
    check_reset("rst_check");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_state.md
# board_state

Game-board state holder for the 6×6 card grid; sits directly upstream of the VGA timing stage. Holds a shuffled layout of 18 card-type pairs, a cursor, and the selection/match state machine. Drives the `hidden`, `blink` and `sel` buses consumed by the display stage. Answers the display stage's per-cell `addr` with that card's colour.

## Interface
Parameters:
- `SEED`, 8'hA5: non-zero reset value of the shuffle LFSR.

Ports:
- `clk100_in`, in, 1: 100 MHz system clock; all logic is on its rising edge.
- `rst_n_in`, in, 1: synchronous, active-low reset.
- `btn_up_in`, `btn_down_in`, `btn_left_in`, `btn_right_in`, in, 1 each: debounced single-cycle move pulses.
- `btn_sel_in`, in, 1: debounced single-cycle select pulse.
- `addr_in`, in, 6: cell index (row×6+col) requested by the display stage.
- `r`, out, 3: red colour for `addr_in`.
- `g`, out, 3: green colour for `addr_in`.
- `b`, out, 2: blue colour for `addr_in`.
- `hidden_bus`, out, 36: bit i=1 means cell i has been matched and removed.
- `blink_bus`, out, 36: one-hot cursor cell; all zero outside IDLE/ONE.
- `sel_bus`, out, 36: bit i=1 means cell i is currently selected.
- `pairs_left`, out, 5: unmatched pairs remaining.
- `cleared`, out, 1: board fully cleared.

## Operation
- Storage: `type[0..35]`, 5 bits each, values 0..17.
- Cursor: `row` and `col`, each 0..5; `cur = row*6+col`.
- First-selection register: `first`, 6 bits.
- States: INIT, SHUFFLE, IDLE, ONE, CHECK, DONE.
- INIT (1 cycle):
  - `type[i] <= i>>1`; LFSR <= `SEED`; shuffle index k <= 0.
  - Go to SHUFFLE.
- SHUFFLE (36 cycles, k=0..35):
  - `j = lfsr[5:0]`, minus 36 if ≥36.
  - Swap `type[k]` and `type[j]`; k=j is a no-op swap.
  - Advance the 8-bit Fibonacci LFSR, taps 8,6,5,4.
  - After k=35, go to IDLE.
- Buttons are ignored in INIT, SHUFFLE, CHECK and DONE.
- Button priority within one cycle: sel, then up, down, left, right. Only the highest-priority active button acts.
- Moves (IDLE and ONE):
  - up: row-1, wraps 0→5.
  - down: row+1, wraps 5→0.
  - left: col-1, wraps 0→5.
  - right: col+1, wraps 5→0.
  - Moves are allowed onto hidden cells.
- IDLE, on sel:
  - If `hidden[cur]`, ignore.
  - Otherwise `first <= cur`, `sel_bus[cur] <= 1`, go to ONE.
- ONE, on sel:
  - If `cur==first`: clear `sel_bus[first]`, go to IDLE (deselect).
  - Else if `hidden[cur]`: ignore.
  - Else `sel_bus[cur] <= 1`, latch second <= cur, go to CHECK.
- CHECK (exactly 1 cycle):
  - Match (`type[first]==type[second]`): set `hidden` for both cells, `pairs_left <= pairs_left-1`.
  - Mismatch: nothing is hidden.
  - In both cases `sel_bus <= 0`.
  - Next state is DONE if a match was made with `pairs_left==1`; otherwise IDLE.
- DONE: `cleared=1`, `blink_bus=0`. Stays in DONE until reset.
- Colour lookup:
  - For `addr_in`<36: `{r,g,b} = 8'd12 + type[addr_in]*8'd13`, giving 12..233 and never 0 or 255.
  - For `addr_in`≥36: `{r,g,b} = 0`.
  - The lookup is independent of the `hidden` bit.

## Timing
- Reset: `rst_n_in` low at a rising edge forces the following on the next edge, regardless of the current state (including mid-SHUFFLE or in CHECK):
  - state=INIT; `hidden_bus`=0; `sel_bus`=0; `blink_bus`=0; `{r,g,b}`=0.
  - `pairs_left`=18; `cleared`=0; row=col=0.
- Reset to IDLE takes 1 INIT + 36 SHUFFLE = 37 cycles after `rst_n_in` returns high.
- `{r,g,b}` is registered: 1-cycle latency from `addr_in`. The display stage compensates with its own input register.
- Button to output: buses and cursor update on the edge after the pulse. `blink_bus` moves 1 cycle after a move pulse.
- A match is visible on `hidden_bus` 2 edges after the second sel pulse: one edge into CHECK, one edge out.
- Pulses arriving during CHECK are dropped, not queued.
- All outputs are registered.

## Test plan
- Reset release, `SEED`=8'hA5 → after 37 cycles the state is IDLE and `blink_bus`=36'h1, `pairs_left`=18, `hidden_bus`=0; reading each of the 36 cell types via `addr_in` shows every type 0..17 exactly twice.
- Press left at (0,0), then up → `blink_bus` bit 5, then bit 35 (row 5, col 5); `addr_in`=40 → `{r,g,b}`=0 one cycle later.
- Select cell 0, select its partner p (found by scanning colours) → `sel_bus` shows bits 0 and p; 2 cycles later `hidden_bus` bits 0 and p are set, `pairs_left`=17, `sel_bus`=0.
- Select two cells of different type → after CHECK `sel_bus`=0, `hidden_bus` unchanged, `pairs_left` unchanged. Selecting the same cell twice → deselect, back to IDLE. Sel on a hidden cell → no change.
- Pulse sel and right in the same cycle → selection is taken, cursor does not move. Pulse left during CHECK → ignored.
- Clear all 18 pairs → `cleared`=1, `pairs_left`=0, `hidden_bus`=all ones, `blink_bus`=0. Assert reset mid-SHUFFLE and mid-game → all outputs return to their reset values the next cycle.
